mem_port_arbiter: RTL and testbench

Two-master arbiter that shares the core's single synchronous memory port between the core (master 0) and a secondary master such as a loader or debug DMA (master 1). It serialises accesses, one outstanding transaction at a time, and returns read data and write acknowledgements to the granting master after a fixed memory latency. A lock mechanism keeps the read-then-write pair of a sub-word store atomic.

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single synchronous memory port: one access in flight,
// optional lock for atomic read-then-write. Define MEM_PORT_ARBITER_RR_EN for round-robin.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 1,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    input  logic        m0_we,
    input  logic        m0_lock,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    input  logic        m1_we,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);

`ifdef MEM_PORT_ARBITER_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif
    localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY - 1);
    localparam logic [7:0] TMO      = 8'(LOCK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        olock_q, olock_d;
    logic        last_q, last_d;
    logic        lock_valid_q, lock_valid_d;
    logic        lock_owner_q, lock_owner_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [7:0]  idle_cnt_q, idle_cnt_d;

    logic        elig0, elig1, grant, win, owner_req;

    // A held lock narrows the eligible set to its owner; ties go to master 0
    // unless round-robin hands it to whoever was not granted last.
    always_comb begin
        elig0     = m0_req && (!lock_valid_q || !lock_owner_q);
        elig1     = m1_req && (!lock_valid_q ||  lock_owner_q);
        grant     = (state_q == IDLE) && (elig0 || elig1) && !reset;
        win       = elig1 && (!elig0 || (RR_EN && !last_q));
        owner_req = lock_owner_q ? m1_req : m0_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            olock_q      <= 1'b0;
            last_q       <= 1'b1;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
            lat_cnt_q    <= '0;
            idle_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            olock_q      <= olock_d;
            last_q       <= last_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            lat_cnt_q    <= lat_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        olock_d      = olock_q;
        last_d       = last_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        lat_cnt_d    = lat_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d    = win;
                    olock_d    = win ? m1_lock : m0_lock;
                    last_d     = win;
                    lat_cnt_d  = LAT_INIT;
                    idle_cnt_d = '0;
                    state_d    = (MEM_LATENCY == 1) ? RESP : WAIT;
                end else if (lock_valid_q && !owner_req) begin
                    // Lock drops on the same edge the counter would reach the timeout.
                    if (idle_cnt_q + 8'd1 == TMO) begin
                        lock_valid_d = 1'b0;
                        idle_cnt_d   = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 8'd1;
                    end
                end
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - 3'd1;
                if (lat_cnt_q <= 3'd1) state_d = RESP;
            end
            RESP: begin
                lock_valid_d = olock_q;
                lock_owner_d = owner_q;
                idle_cnt_d   = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (grant) begin
            m0_gnt    = !win;
            m1_gnt    = win;
            mem_en    = 1'b1;
            mem_we    = win ? m1_we    : m0_we;
            mem_addr  = win ? m1_addr  : m0_addr;
            mem_wdata = win ? m1_wdata : m0_wdata;
            mem_be    = win ? m1_be    : m0_be;
        end
        if (state_q == RESP && !reset) begin
            if (owner_q) begin
                m1_rvalid = 1'b1;
                m1_rdata  = mem_rdata;
            end else begin
                m0_rvalid = 1'b1;
                m0_rdata  = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LATENCY=2, LOCK_TIMEOUT=4) with a
// latency-2 memory model and a response scoreboard.
module tb_mem_port_arbiter;
    localparam int LAT = 2;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    mem_port_arbiter #(.MEM_LATENCY(LAT), .LOCK_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_we(m0_we), .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_we(m1_we), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model: word-indexed, two-cycle read pipeline, byte-enabled writes.
    logic [31:0] mem [256];
    logic [31:0] rd1, rd2;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h5A000000 | 32'(i);
            mem[8'h40] <= 32'hDEADBEEF;
            rd1 <= '0;
            rd2 <= '0;
        end else begin
            if (mem_en) begin
                rd1 <= mem[mem_addr[9:2]];
                if (mem_we)
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            rd2 <= rd1;
        end
    end
    assign mem_rdata = rd2;

    typedef struct {
        logic        m;
        logic        rd;
        logic [31:0] data;
        int          gcyc;
    } exp_t;
    exp_t sb[$];
    int   gorder[$];
    exp_t me;

    // Response monitor: every rvalid must match the oldest outstanding grant.
    always @(negedge clk) begin
        if (!reset) begin
            if (m0_gnt) gorder.push_back(0);
            if (m1_gnt) gorder.push_back(1);
            if (m0_rvalid || m1_rvalid) begin
                chk("one_rvalid", 32'(m0_rvalid & m1_rvalid), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_rvalid", 32'({m1_rvalid, m0_rvalid}), 0);
                end else begin
                    me = sb.pop_front();
                    chk("rvalid_owner", 32'(m1_rvalid), 32'(me.m));
                    chk("rsp_latency", 32'(cyc - me.gcyc), LAT);
                    if (me.rd) chk("rdata", me.m ? m1_rdata : m0_rdata, me.data);
                    chk("other_rdata_zero", me.m ? m0_rdata : m1_rdata, 0);
                end
            end
        end
    end

    task automatic drive(input bit m, input logic req, input logic [31:0] addr, input logic we,
                         input logic [31:0] wd, input logic [3:0] be, input logic lk);
        if (m) begin
            m1_req = req; m1_addr = addr; m1_we = we; m1_wdata = wd; m1_be = be; m1_lock = lk;
        end else begin
            m0_req = req; m0_addr = addr; m0_we = we; m0_wdata = wd; m0_be = be; m0_lock = lk;
        end
    endtask

    task automatic xact(input bit m, input logic [31:0] addr, input logic we, input logic [31:0] wd,
                        input logic [3:0] be, input logic lk,
                        output int gcyc, output int waited, output logic [31:0] rd);
        exp_t e;
        bit   got;
        @(posedge clk); #1;
        drive(m, 1'b1, addr, we, wd, be, lk);
        waited = 0; got = 0; gcyc = -1; rd = '0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (m ? m1_gnt : m0_gnt) begin
                got  = 1;
                gcyc = cyc;
                chk("mem_en", 32'(mem_en), 1);
                chk("mem_addr", mem_addr, addr);
                chk("mem_we", 32'(mem_we), 32'(we));
                chk("mem_be", 32'(mem_be), 32'(be));
                if (we) chk("mem_wdata", mem_wdata, wd);
                chk("other_gnt", 32'(m ? m0_gnt : m1_gnt), 0);
                e.m = m; e.rd = !we; e.data = mem[addr[9:2]]; e.gcyc = cyc;
                sb.push_back(e);
            end else begin
                waited++;
            end
        end
        chk("gnt_seen", 32'(got), 1);
        @(posedge clk); #1;
        drive(m, 1'b0, addr, we, wd, be, 1'b0);
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (m ? m1_rvalid : m0_rvalid) begin
                got = 1;
                rd  = m ? m1_rdata : m0_rdata;
            end
        end
        chk("rvalid_seen", 32'(got), 1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_strobes"}, 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we}), 0);
        chk({tag, "_rdata"}, m0_rdata | m1_rdata, 0);
        chk({tag, "_mem"}, mem_addr | mem_wdata | 32'(mem_be), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          ga, gb, gc, wa, wb, wc;
        logic [31:0] ra, rb, rc;
        int          exp_ord[6];
        int          n;

        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, '0, 4'h0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0, '0, 4'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("in_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_quiet("after_reset");

        // Single read, then a second master queued behind it.
        fork
            xact(1'b0, 32'h100, 1'b0, '0, 4'hF, 1'b0, ga, wa, ra);
            begin
                @(posedge clk);
                xact(1'b1, 32'h104, 1'b0, '0, 4'hF, 1'b0, gb, wb, rb);
            end
        join
        chk("single_rdata", ra, 32'hDEADBEEF);
        chk("single_nowait", 32'(wa), 0);
        chk("next_grant_gap", 32'(gb - ga), LAT + 1);
        chk("queued_rdata", rb, 32'h5A000041);

        // Continuous contention.
        gorder.delete();
        fork
            for (int i = 0; i < 3; i++) xact(1'b0, 32'h10 + 32'(4*i), 1'b0, '0, 4'hF, 1'b0, ga, wa, ra);
            for (int i = 0; i < 3; i++) xact(1'b1, 32'h40 + 32'(4*i), 1'b0, '0, 4'hF, 1'b0, gb, wb, rb);
        join
`ifdef MEM_PORT_ARBITER_RR_EN
        exp_ord = '{0, 1, 0, 1, 0, 1};
`else
        exp_ord = '{0, 0, 0, 1, 1, 1};
`endif
        chk("contend_count", 32'(gorder.size()), 6);
        n = (gorder.size() < 6) ? gorder.size() : 6;
        for (int i = 0; i < n; i++) chk($sformatf("contend_order%0d", i), 32'(gorder[i]), 32'(exp_ord[i]));

        // Locked read-modify-write by m1 while m0 keeps asking.
        gorder.delete();
        fork
            begin
                xact(1'b1, 32'h200, 1'b0, '0, 4'hF, 1'b1, ga, wa, ra);
                xact(1'b1, 32'h200, 1'b1, 32'h00AB0000, 4'h4, 1'b0, gb, wb, rb);
            end
            begin
                @(posedge clk);
                xact(1'b0, 32'h300, 1'b0, '0, 4'hF, 1'b0, gc, wc, rc);
            end
        join
        chk("rmw_count", 32'(gorder.size()), 3);
        n = (gorder.size() < 3) ? gorder.size() : 3;
        for (int i = 0; i < n; i++) chk($sformatf("rmw_order%0d", i), 32'(gorder[i]), (i < 2) ? 1 : 0);
        chk("rmw_read", ra, 32'h5A000080);
        chk("rmw_back_to_back", 32'(gb - ga), LAT + 1);
        chk("rmw_m0_next", 32'(gc - gb), LAT + 1);
        xact(1'b0, 32'h200, 1'b0, '0, 4'hF, 1'b0, ga, wa, ra);
        chk("rmw_merged", ra, 32'h5AAB0080);

        // Lock abandoned by m1: m0 waits out the timeout.
        fork
            xact(1'b1, 32'h204, 1'b0, '0, 4'hF, 1'b1, ga, wa, ra);
            begin
                @(posedge clk);
                xact(1'b0, 32'h208, 1'b0, '0, 4'hF, 1'b0, gc, wc, rc);
            end
        join
        chk("timeout_grant", 32'(gc - ga), LAT + TMO + 1);

        // Reset while m1 holds the lock and has an access in flight.
        xact(1'b1, 32'h20C, 1'b0, '0, 4'hF, 1'b1, ga, wa, ra);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 32'h210, 1'b0, '0, 4'hF, 1'b1);
        @(negedge clk);
        chk("prerst_owner_gnt", 32'(m1_gnt), 1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h210, 1'b0, '0, 4'hF, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_quiet($sformatf("post_rst%0d", i));
        end
        xact(1'b0, 32'h100, 1'b0, '0, 4'hF, 1'b0, ga, wa, ra);
        chk("post_rst_nowait", 32'(wa), 0);
        chk("post_rst_rdata", ra, 32'hDEADBEEF);

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
